// File: rtl/oc_thermo_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oc_pkg
//  Description : Shared constants, FSM state type and thermometer helper for
//                the ones-count serializer and its reference decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package oc_pkg;

  // Data bits per frame; matches the ones-counter input width.
  localparam int N_BITS = 7;
  // Width of a ones count able to express 0..N_BITS.
  localparam int CW     = $clog2(N_BITS + 1);
  // Width of the data-bit index inside a frame.
  localparam int IDX_W  = $clog2(N_BITS);

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Thermometer word with min(count, N_BITS) ones packed at the LSB end.
  // Any count above N_BITS sets every bit, so saturation falls out of the
  // compare without a separate clamp.
  function automatic logic [N_BITS-1:0] thermo(input logic [CW-1:0] count);
    logic [N_BITS-1:0] t;
    t = '0;
    for (int i = 0; i < N_BITS; i++) begin
      t[i] = (int'(count) > i);
    end
    return t;
  endfunction

endpackage : oc_pkg
`default_nettype wire

// File: rtl/oc_thermo_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : oc_thermo_serializer_if
//  Description : Count-offer handshake between a count source (master) and
//                the thermometer serializer (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface oc_thermo_serializer_if;
  import oc_pkg::*;

  logic          in_valid;  // count is offered
  logic          in_ready;  // serializer can take a count this cycle
  logic [CW-1:0] count;     // requested number of ones

  modport master (
    output in_valid,
    output count,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  count,
    output in_ready
  );

endinterface : oc_thermo_serializer_if
`default_nettype wire

// File: rtl/oc_thermo_serializer_decode.sv
`default_nettype none
// ============================================================================
//  Module      : oc_thermo_decode
//  Description : Purely combinational ones-count to thermometer-word decoder.
//                Also usable as the reference model for the ones-counter.
//  Revision    : 1.0  initial release
// ============================================================================
module oc_thermo_decode
  import oc_pkg::*;
(
  input  wire logic [CW-1:0]     count,
  output logic      [N_BITS-1:0] word
);

  // Saturating thermometer decode of the requested count.
  always_comb begin
    word = thermo(count);
  end

endmodule : oc_thermo_decode
`default_nettype wire

// File: rtl/oc_thermo_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : oc_thermo_serializer
//  Description : Accepts a ones count over a valid/ready handshake, rebuilds
//                the canonical thermometer word and shifts it out LSB first
//                as a start bit / N_BITS data bits / stop bit frame. The line
//                idles high. All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module oc_thermo_serializer
  import oc_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst,
  oc_thermo_serializer_if.slave  bus,
  output logic      [N_BITS-1:0] word,
  output logic                   sout,
  output logic                   busy,
  output logic                   frame_done
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [N_BITS-1:0]  r_word;
  logic               r_sout;
  logic               r_busy;
  logic               r_frame_done;
  logic               r_in_ready;

  logic [N_BITS-1:0]  w_decoded;
  logic [IDX_W-1:0]   w_idx_next;
  logic               w_xfer;

  // Count-to-word decode sits ahead of the word register so the word is
  // ready in the same edge that accepts the count.
  oc_thermo_decode u_decode (
    .count (bus.count),
    .word  (w_decoded)
  );

  // A transfer needs only the registered ready, so in_valid never reaches an
  // output through combinational logic.
  assign w_xfer     = bus.in_valid && r_in_ready;
  assign w_idx_next = r_idx + IDX_W'(1);

  assign bus.in_ready = r_in_ready;
  assign word         = r_word;
  assign sout         = r_sout;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;

  // Frame sequencer: every output is set up for the state being entered, so
  // the registered values line up with the state they belong to. in_ready
  // stays low through reset and rises on the first clock afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_word       <= '0;
      r_sout       <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_frame_done <= 1'b0;
          if (w_xfer) begin
            r_state    <= START;
            r_word     <= w_decoded;
            r_sout     <= 1'b0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
          end else begin
            r_sout     <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end

        START: begin
          // Start bit is on the line now; first data bit follows.
          r_state <= DATA;
          r_idx   <= '0;
          r_sout  <= r_word[0];
        end

        DATA: begin
          if (r_idx == IDX_W'(N_BITS - 1)) begin
            r_state      <= STOP;
            r_idx        <= '0;
            r_sout       <= 1'b1;
            r_frame_done <= 1'b1;
            r_in_ready   <= 1'b1;
          end else begin
            r_idx  <= w_idx_next;
            r_sout <= r_word[w_idx_next];
          end
        end

        STOP: begin
          r_frame_done <= 1'b0;
          if (w_xfer) begin
            // Back-to-back frame: straight into the next start bit.
            r_state    <= START;
            r_word     <= w_decoded;
            r_sout     <= 1'b0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
          end else begin
            r_state    <= IDLE;
            r_sout     <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end

        default: begin
          r_state      <= IDLE;
          r_idx        <= '0;
          r_sout       <= 1'b1;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
          r_in_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule : oc_thermo_serializer
`default_nettype wire

// File: tb/tb_oc_thermo_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oc_thermo_serializer
//  Description : Directed self-checking bench for oc_thermo_serializer.
//                Outputs are sampled on the falling edge; inputs change there.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_oc_thermo_serializer;

  logic       clk;
  logic       rst;
  logic [6:0] word;
  logic       sout;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  oc_thermo_serializer_if bus ();

  oc_thermo_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .word       (word),
    .sout       (sout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and count and report a miss.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer count c for one edge, then present keep/nextc on the inputs, and
  // record sout/frame_done/in_ready/busy over the 9 frame cycles T+1..T+9.
  // pulse_at >= 0 raises in_valid with count=5 for one cycle after sample
  // pulse_at. Returns sitting in cycle T+9.
  task automatic frame(input logic [2:0] c, input logic keep, input logic [2:0] nextc,
                       input int pulse_at,
                       output logic [8:0] s, output logic [8:0] fd,
                       output logic [8:0] rd, output logic [8:0] bz);
    bus.count    = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = keep;
    bus.count    = nextc;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      s[i]  = sout;
      fd[i] = frame_done;
      rd[i] = bus.in_ready;
      bz[i] = busy;
      if (i == pulse_at) begin
        bus.in_valid = 1'b1;
        bus.count    = 3'd5;
      end else if (pulse_at >= 0 && i == pulse_at + 1) begin
        bus.in_valid = keep;
        bus.count    = nextc;
      end
    end
  endtask

  // Expected serial frame for count c: stop(1), thermometer data, start(0).
  function automatic logic [8:0] exp_frame(input int c);
    logic [6:0] w;
    w = 7'((1 << c) - 1);
    return {1'b1, w, 1'b0};
  endfunction

  logic [8:0] s, fd, rd, bz;
  int         ones;
  logic       saw_fd;

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.count    = 3'd0;

    // Reset state, with clock edges passing while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_sout",     32'(sout),         32'd1);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_word",     32'(word),         32'd0);
    chk("rst_fdone",    32'(frame_done),   32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;

    // Idle five cycles after release.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_sout",     32'(sout),         32'd1);
      chk("idle_busy",     32'(busy),         32'd0);
      chk("idle_word",     32'(word),         32'd0);
      chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    end

    // Single frame, count=3.
    frame(3'd3, 1'b0, 3'd0, -1, s, fd, rd, bz);
    chk("c3_word",  32'(word), 32'h07);
    chk("c3_sout",  32'(s),    32'(9'b1_0000111_0));
    chk("c3_fdone", 32'(fd),   32'(9'b1_0000000_0));
    chk("c3_ready", 32'(rd),   32'(9'b1_0000000_0));
    chk("c3_busy",  32'(bz),   32'(9'b1_1111111_1));
    @(negedge clk);
    chk("c3_after_sout",  32'(sout),       32'd1);
    chk("c3_after_busy",  32'(busy),       32'd0);
    chk("c3_after_fdone", 32'(frame_done), 32'd0);
    chk("c3_after_word",  32'(word),       32'h07);

    // Back-to-back: count 0 then count 7 with in_valid held high.
    frame(3'd0, 1'b1, 3'd7, -1, s, fd, rd, bz);
    chk("b2b0_word",  32'(word), 32'h00);
    chk("b2b0_sout",  32'(s),    32'(9'b1_0000000_0));
    chk("b2b0_ready", 32'(rd),   32'(9'b1_0000000_0));
    frame(3'd7, 1'b0, 3'd0, -1, s, fd, rd, bz);
    chk("b2b7_word",  32'(word), 32'h7F);
    chk("b2b7_sout",  32'(s),    32'(9'b1_1111111_0));
    chk("b2b7_busy",  32'(bz),   32'(9'b1_1111111_1));
    chk("b2b7_ready", 32'(rd),   32'(9'b1_0000000_0));
    chk("b2b7_fdone", 32'(fd),   32'(9'b1_0000000_0));
    @(negedge clk);

    // in_valid pulsed with count=5 in the middle of a count=2 frame.
    frame(3'd2, 1'b0, 3'd0, 3, s, fd, rd, bz);
    chk("ign_word", 32'(word), 32'h03);
    chk("ign_sout", 32'(s),    32'(9'b1_0000011_0));
    chk("ign_busy", 32'(bz),   32'(9'b1_1111111_1));
    @(negedge clk);
    chk("ign_idle_word", 32'(word), 32'h03);
    chk("ign_idle_busy", 32'(busy), 32'd0);

    // Reset at T+4 of a count=6 frame.
    bus.count    = 3'd6;
    bus.in_valid = 1'b1;
    @(negedge clk);              // cycle T+1
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);   // cycle T+4, inside the data bits
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;                          // no clock edge in between
    chk("mid_rst_sout",  32'(sout),         32'd1);
    chk("mid_rst_busy",  32'(busy),         32'd0);
    chk("mid_rst_fdone", 32'(frame_done),   32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_word",  32'(word),         32'd0);
    saw_fd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (frame_done) saw_fd = 1'b1;
    end
    chk("mid_no_fdone", 32'(saw_fd),       32'd0);
    chk("mid_ready",    32'(bus.in_ready), 32'd1);

    // Loopback through a ones-counter model for every count value.
    for (int c = 0; c < 8; c++) begin
      frame(3'(c), 1'b0, 3'd0, -1, s, fd, rd, bz);
      ones = 0;
      for (int b = 1; b <= 7; b++) ones += int'(s[b]);
      chk($sformatf("loop%0d_count", c), 32'(ones), 32'(c));
      chk($sformatf("loop%0d_frame", c), 32'(s),    32'(exp_frame(c)));
      chk($sformatf("loop%0d_fdone", c), 32'(fd),   32'(9'b1_0000000_0));
    end
    @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_sout", 32'(sout), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_oc_thermo_serializer
`default_nettype wire
